// File: rtl/led_ctrl_pkg.sv
// Shared types, register offsets and field widths for the LED output peripheral.
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    LED_OFF   = 2'd0,
    LED_ON    = 2'd1,
    LED_BLINK = 2'd2,
    LED_PWM   = 2'd3
  } led_mode_e;

  localparam logic [3:0] CTRL_OFF  = 4'h0;
  localparam logic [3:0] BLINK_OFF = 4'h4;
  localparam logic [3:0] DUTY_OFF  = 4'h8;
  localparam logic [3:0] STAT_OFF  = 4'hC;

  localparam int unsigned BLINK_W = 24;
  localparam int unsigned DUTY_W  = 8;

  // Expands per-byte write strobes into a 32-bit bit mask.
  function automatic logic [31:0] be_mask(input logic [3:0] be);
    logic [31:0] m;
    m = '0;
    for (int unsigned b = 0; b < 4; b++) begin
      m[8*b +: 8] = {8{be[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/led_pwm_gen.sv
// Shared free-running PWM counter with per-LED duty compare.
module led_pwm_gen
  import led_ctrl_pkg::*;
#(
  parameter int unsigned NUM_LED = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_LED*DUTY_W-1:0] duty_i,
  output logic [DUTY_W-1:0]         cnt_o,
  output logic [NUM_LED-1:0]        on_o
);

  logic [DUTY_W-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  always_comb begin
    on_o = '0;
    for (int unsigned i = 0; i < NUM_LED; i++) begin
      on_o[i] = (cnt_q < duty_i[DUTY_W*i +: DUTY_W]);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/led_ctrl.sv
// Memory-mapped LED peripheral: register file, blink engine and registered
// output mux; PWM generation lives in led_pwm_gen.
module led_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int unsigned        NUM_LED        = 4,
  parameter logic [BLINK_W-1:0] BLINK_DIV_RST  = 24'd12_499_999,
  parameter logic               LED_ACTIVE_LOW = 1'b0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               device_req_i,
  input  logic [31:0]        device_addr_i,
  input  logic               device_we_i,
  input  logic [3:0]         device_be_i,
  input  logic [31:0]        device_wdata_i,
  output logic               device_rvalid_o,
  output logic [31:0]        device_rdata_o,
  output logic               device_err_o,
  output logic [NUM_LED-1:0] led_o
);

  logic [7:0]         ctrl_q, ctrl_d;
  logic [BLINK_W-1:0] div_q, div_d;
  logic [BLINK_W-1:0] bcnt_q, bcnt_d;
  logic [31:0]        duty_q, duty_d;
  logic               phase_q, phase_d;
  logic [NUM_LED-1:0] led_q, led_d;
  logic               rvalid_q;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;

  logic [DUTY_W-1:0]  pwm_cnt;
  logic [NUM_LED-1:0] pwm_on;
  logic [3:0]         reg_off;
  logic               acc_ok, wr_en, div_wr;
  logic [31:0]        be_m;
  logic               unused_addr;

  led_pwm_gen #(
    .NUM_LED(NUM_LED)
  ) u_pwm (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .duty_i(duty_q[NUM_LED*DUTY_W-1:0]),
    .cnt_o (pwm_cnt),
    .on_o  (pwm_on)
  );

  always_comb unused_addr = ^device_addr_i[31:4];

  // Register file: writes and reads both see the pre-write register state.
  always_comb begin
    reg_off = {device_addr_i[3:2], 2'b00};
    acc_ok  = device_req_i && (device_addr_i[1:0] == 2'b00);
    wr_en   = acc_ok && device_we_i;
    be_m    = be_mask(device_be_i);
    ctrl_d  = ctrl_q;
    div_d   = div_q;
    duty_d  = duty_q;
    rdata_d = '0;
    err_d   = device_req_i && !acc_ok;
    if (wr_en) begin
      case (reg_off)
        CTRL_OFF:  ctrl_d = (ctrl_q & ~be_m[7:0]) | (device_wdata_i[7:0] & be_m[7:0]);
        BLINK_OFF: div_d  = (div_q & ~be_m[BLINK_W-1:0]) | (device_wdata_i[BLINK_W-1:0] & be_m[BLINK_W-1:0]);
        DUTY_OFF:  duty_d = (duty_q & ~be_m) | (device_wdata_i & be_m);
        default:   ;
      endcase
    end
    if (acc_ok && !device_we_i) begin
      case (reg_off)
        CTRL_OFF:  rdata_d = {24'b0, ctrl_q};
        BLINK_OFF: rdata_d = {8'b0, div_q};
        DUTY_OFF:  rdata_d = duty_q;
        STAT_OFF:  rdata_d = {16'b0, pwm_cnt, 7'b0, phase_q};
        default:   rdata_d = '0;
      endcase
    end
  end

  // A BLINK_DIV write restarts the half-period with the new value, phase held.
  always_comb begin
    div_wr  = wr_en && (reg_off == BLINK_OFF) && (|device_be_i);
    bcnt_d  = bcnt_q - 1'b1;
    phase_d = phase_q;
    if (div_wr) begin
      bcnt_d = div_d;
    end else if (bcnt_q == '0) begin
      bcnt_d  = div_q;
      phase_d = !phase_q;
    end
  end

  always_comb begin
    led_d = '0;
    for (int unsigned i = 0; i < NUM_LED; i++) begin
      case (led_mode_e'(ctrl_q[2*i +: 2]))
        LED_OFF:   led_d[i] = 1'b0;
        LED_ON:    led_d[i] = 1'b1;
        LED_BLINK: led_d[i] = phase_q;
        LED_PWM:   led_d[i] = pwm_on[i];
        default:   led_d[i] = 1'b0;
      endcase
      led_d[i] = led_d[i] ^ LED_ACTIVE_LOW;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ctrl_q   <= '0;
      div_q    <= BLINK_DIV_RST;
      duty_q   <= '0;
      bcnt_q   <= BLINK_DIV_RST;
      phase_q  <= 1'b0;
      led_q    <= {NUM_LED{LED_ACTIVE_LOW}};
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      div_q    <= div_d;
      duty_q   <= duty_d;
      bcnt_q   <= bcnt_d;
      phase_q  <= phase_d;
      led_q    <= led_d;
      rvalid_q <= device_req_i;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign device_rvalid_o = rvalid_q;
  assign device_rdata_o  = rdata_q;
  assign device_err_o    = err_q;
  assign led_o           = led_q;

endmodule
